// File: rtl/tc_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register
// offsets, CTRL field layout, MODE encodings and FSM state codes.
package tc_pkg;

  // Word offsets seen on addr (byte address bits [3:2]).
  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  // CTRL.MODE encodings; anything other than TC_RELOAD behaves as one-shot.
  localparam logic [1:0] TC_ONESHOT = 2'b00;
  localparam logic [1:0] TC_RELOAD  = 2'b01;

  // CTRL bit positions.
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // FSM state codes, kept as plain 2-bit constants for legacy tooling.
  typedef logic [1:0] tc_state_t;
  localparam tc_state_t ST_IDLE = 2'd0;
  localparam tc_state_t ST_LOAD = 2'd1;
  localparam tc_state_t ST_CNT  = 2'd2;
  localparam tc_state_t ST_INT  = 2'd3;

endpackage

// File: rtl/timer_counter.sv
// Countdown timer on the system bridge. Software programs CTRL/PRESET and
// reads COUNT; on expiry the timer raises a level (one-shot) or a single
// cycle pulse (auto-reload) on irq, which feeds CP0 HWInt[0].
module timer_counter
  import tc_pkg::*;
#(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] PRESET_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [CNT_W-1:0] din,
  output logic [CNT_W-1:0] dout,
  output logic             irq
);

  logic [CTRL_W-1:0] ctrl;
  logic [CNT_W-1:0]  preset;
  logic [CNT_W-1:0]  count;
  logic              irq_pending;
  tc_state_t         state;

  // FSM next-state outputs consumed by the register file.
  tc_state_t         state_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              pend_set;
  logic              pend_clr;
  logic              en_clr;

  logic              ctrl_en;
  logic [1:0]        ctrl_mode;
  logic              ctrl_im;
  logic              ctrl_wr;
  logic              preset_wr;

  assign ctrl_en   = ctrl[CTRL_EN];
  assign ctrl_mode = ctrl[CTRL_MODE_HI:CTRL_MODE_LO];
  assign ctrl_im   = ctrl[CTRL_IM];
  assign ctrl_wr   = we && (addr == TC_CTRL);
  assign preset_wr = we && (addr == TC_PRESET);

  // Countdown FSM: next state, next COUNT and pending/enable side effects.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    count_nxt = count;
    pend_set  = 1'b0;
    pend_clr  = 1'b0;
    en_clr    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctrl_en) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        count_nxt = preset;
        state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_en) begin
          state_nxt = ST_IDLE;
        end else if (count > CNT_W'(1)) begin
          count_nxt = count - CNT_W'(1);
        end else begin
          // Covers COUNT==1 and COUNT==0 (PRESET=0): saturate, never wrap.
          count_nxt = '0;
          pend_set  = 1'b1;
          state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (ctrl_mode == TC_RELOAD) begin
          pend_clr  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          en_clr    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state and COUNT registers.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Software-visible registers; a CTRL write overrides FSM updates to EN and pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl        <= '0;
      preset      <= PRESET_INIT;
      irq_pending <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        ctrl        <= din[CTRL_W-1:0];
        irq_pending <= 1'b0;
      end else begin
        if (en_clr) ctrl[CTRL_EN] <= 1'b0;
        if (pend_set)      irq_pending <= 1'b1;
        else if (pend_clr) irq_pending <= 1'b0;
      end
      if (preset_wr) preset <= din;
    end
  end

  // Side-effect-free read mux; CTRL upper bits and the reserved slot read 0.
  always_comb begin
    dout = '0;
    case (addr)
      TC_CTRL:   dout[CTRL_W-1:0] = ctrl;
      TC_PRESET: dout = preset;
      TC_COUNT:  dout = count;
      default:   dout = '0;
    endcase
  end

  // Interrupt comes only from flops, never combinationally from the bus.
  assign irq = irq_pending & ctrl_im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: reset values, one-shot, auto-reload,
// masking, PRESET=0, PRESET update mid-count, and reset mid-count.
module tb_timer_counter;
  import tc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int pulses;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bus write consumed on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, dout, exp);
  endtask

  initial begin
    reset = 1'b0;
    addr  = 2'd0;
    we    = 1'b0;
    din   = '0;

    // Reset state.
    tick_n(2);
    rd("rst_ctrl", TC_CTRL, 32'h0);
    rd("rst_preset", TC_PRESET, 32'h0);
    rd("rst_count", TC_COUNT, 32'h0);
    check("rst_irq", irq, 1'b0);
    reset = 1'b1;
    tick_n(2);
    rd("idle_count", TC_COUNT, 32'h0);

    // One-shot, PRESET=3: COUNT 3,2,1 after E2..E4, irq after E5, held.
    wr(TC_PRESET, 32'd3);
    wr(TC_CTRL, 32'h9);                   // E0
    tick();                               // E1
    tick(); rd("os_cnt_e2", TC_COUNT, 32'd3); check("os_irq_e2", irq, 1'b0);
    tick(); rd("os_cnt_e3", TC_COUNT, 32'd2);
    tick(); rd("os_cnt_e4", TC_COUNT, 32'd1); check("os_irq_e4", irq, 1'b0);
    tick(); check("os_irq_e5", irq, 1'b1); rd("os_cnt_e5", TC_COUNT, 32'd0);
    tick(); check("os_irq_e6", irq, 1'b1); rd("os_ctrl_e6", TC_CTRL, 32'h8);
    tick_n(3); check("os_irq_held", irq, 1'b1);
    wr(TC_CTRL, 32'h8);
    check("os_irq_clr", irq, 1'b0);
    tick(); check("os_irq_clr2", irq, 1'b0);

    // Auto-reload, PRESET=2: one-cycle pulse every 4 cycles.
    wr(TC_PRESET, 32'd2);
    wr(TC_CTRL, 32'hB);                   // E0
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("ar_irq_e%0d", k), irq, (k % 4 == 0) ? 1'b1 : 1'b0);
      if (irq) pulses++;
    end
    check("ar_pulses", pulses, 32'd10);
    wr(TC_CTRL, 32'h0);
    tick_n(4);

    // Masked expiry, PRESET=1, IM=0.
    wr(TC_PRESET, 32'd1);
    wr(TC_CTRL, 32'h1);                   // E0
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("mask_irq_e%0d", k), irq, 1'b0);
    end
    rd("mask_ctrl", TC_CTRL, 32'h0);
    wr(TC_CTRL, 32'h8);                   // clears pending, so unmasking raises nothing
    check("mask_unmask", irq, 1'b0);
    tick(); check("mask_unmask2", irq, 1'b0);

    // PRESET=0: COUNT=0 after LOAD, irq after E3.
    wr(TC_PRESET, 32'd0);
    wr(TC_CTRL, 32'h9);                   // E0
    tick();
    tick(); rd("p0_cnt_e2", TC_COUNT, 32'd0); check("p0_irq_e2", irq, 1'b0);
    tick(); check("p0_irq_e3", irq, 1'b1);
    wr(TC_CTRL, 32'h8);
    check("p0_clr", irq, 1'b0);
    tick_n(2);

    // PRESET rewritten mid-count in reload mode takes effect at next LOAD.
    wr(TC_PRESET, 32'd3);
    wr(TC_CTRL, 32'hB);                   // E0
    tick();
    tick(); rd("pw_cnt_e2", TC_COUNT, 32'd3);
    wr(TC_PRESET, 32'd5);                 // E3
    rd("pw_cnt_e3", TC_COUNT, 32'd2);
    rd("pw_preset", TC_PRESET, 32'd5);
    tick(); rd("pw_cnt_e4", TC_COUNT, 32'd1);
    tick(); check("pw_irq_e5", irq, 1'b1);
    tick(); check("pw_irq_e6", irq, 1'b0);
    tick(); rd("pw_cnt_e7", TC_COUNT, 32'd5);
    for (int k = 8; k <= 11; k++) begin
      tick();
      check($sformatf("pw_irq_e%0d", k), irq, 1'b0);
      rd($sformatf("pw_cnt_e%0d", k), TC_COUNT, 32'(12 - k));
    end
    tick(); check("pw_irq_e12", irq, 1'b1);
    wr(TC_CTRL, 32'h0);
    tick_n(4);

    // Reset while counting with COUNT=7.
    wr(TC_PRESET, 32'd10);
    wr(TC_CTRL, 32'h9);                   // E0
    tick_n(5);
    rd("rm_cnt_e5", TC_COUNT, 32'd7);
    check("rm_irq_pre", irq, 1'b0);
    reset = 1'b0;
    #1;
    check("rm_irq", irq, 1'b0);
    rd("rm_ctrl", TC_CTRL, 32'h0);
    rd("rm_preset", TC_PRESET, 32'h0);
    rd("rm_count", TC_COUNT, 32'h0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      rd($sformatf("rm_idle_cnt%0d", k), TC_COUNT, 32'h0);
      check($sformatf("rm_idle_irq%0d", k), irq, 1'b0);
    end
    // Restart from the reset PRESET value (0): irq after E3.
    wr(TC_CTRL, 32'h9);
    tick_n(2); check("rs_irq_e2", irq, 1'b0);
    tick();    check("rs_irq_e3", irq, 1'b1);

    // CTRL upper bits read as 0; reserved offset reads 0.
    wr(TC_CTRL, 32'hFFFF_FFF8);
    rd("ctrl_upper", TC_CTRL, 32'h8);
    check("ctrl_wr_clr", irq, 1'b0);
    rd("reserved", 2'd3, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
